s7_scan_decoder: RTL and testbench
==================================

S7_SCAN_DECODER -- requirements
Module: s7_scan_decoder

Interface
REQ-001 Parameter DIS_NUM, default 6: number of multiplexed digits.
REQ-002 Parameter SETTLE, default 2: consecutive cycles a select/segment pair must stay stable before capture (1..15).
REQ-003 Parameter SEG_ACTIVE_LOW, default 1: segment lit level is 0.
REQ-004 Parameter SEL_ACTIVE_LOW, default 1: digit-select active level is 0.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_segments  in  7  segment lines, bit0=a ... bit6=g.
REQ-008 i_segments_sel  in  DIS_NUM  digit select, one-hot at active level; bit k = digit k.
REQ-009 o_bcd_data  out  4*DIS_NUM  reconstructed frame; digit k at [4k+3:4k], digit 0 least significant.
REQ-010 o_valid  out  1  one-cycle pulse: o_bcd_data updated with a complete frame.
REQ-011 o_err  out  1  one-cycle pulse: a settled digit carried an undecodable pattern.

Function
REQ-012 Inputs SHALL be registered once; all decisions use the registered copies (one-cycle input latency).
REQ-013 Segments SHALL be normalised to active-high, then decoded: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9 (bits g..a); any other pattern is invalid.
REQ-014 Select SHALL be normalised to active-high; it is valid only when exactly one bit is set.
REQ-015 FSM states: IDLE, SETTLE, HOLD.
REQ-016 IDLE: on valid select -> SETTLE, load stability counter with 1, latch select and segments as reference.
REQ-017 SETTLE: if select or segments differ from the reference -> reload reference, counter=1 (stay SETTLE if select valid, else IDLE); else increment; on reaching SETTLE -> capture, go to HOLD.
REQ-018 Capture: valid pattern writes the decoded digit into shadow register slot k and sets captured-mask bit k; invalid pattern pulses o_err for one cycle, mask unchanged.
REQ-019 HOLD: stay until select or segments change; then behave as IDLE on the same cycle (valid select -> SETTLE, else IDLE). A digit is captured at most once per select dwell.
REQ-020 Re-capture of an already-masked digit before frame completion SHALL overwrite its shadow slot.
REQ-021 The cycle after the mask becomes all ones, o_bcd_data SHALL load the shadow register, o_valid SHALL pulse, mask SHALL clear; a capture coinciding with the clear lands in the new frame.
REQ-022 o_bcd_data SHALL hold its value between o_valid pulses.
REQ-023 Invalid select (zero or multi-hot) in any state SHALL force IDLE without capture.
REQ-024 Latency: digit change to capture = 1 + SETTLE cycles; last capture to o_valid = 1 cycle.

Reset
REQ-025 Asynchronous i_rst SHALL force: FSM IDLE, counter 0, mask 0, shadow 0, o_bcd_data 0, o_valid 0, o_err 0, input registers to inactive levels.
REQ-026 Reset mid-frame SHALL discard the partial frame; no o_valid until a full new frame is captured.

Structure
REQ-027 Shared package s7_pkg SHALL hold the ten segment pattern constants (active-high, g..a) and FSM state encodings, shared with the display driver.
REQ-028 Sub-module s7_seg_decode (combinational: 7-bit pattern -> 4-bit BCD + valid flag) SHALL be instantiated once.

Verification
REQ-029 Drive 123456 (digits 0..5 = 6,5,4,3,2,1), 4 cycles per digit, active-low -> o_valid after digit 5 settles, o_bcd_data=0x123456.
REQ-030 Digit dwell of 1 cycle with SETTLE=2 -> no capture, no o_valid, no o_err.
REQ-031 Digit 3 pattern 0x49 (invalid) for 4 cycles -> one o_err pulse; no o_valid until digit 3 shows a valid pattern.
REQ-032 Select 0b000011 (multi-hot, active-high) held 10 cycles -> FSM IDLE, no capture.
REQ-033 Assert i_rst after 4 of 6 digits captured -> outputs 0; next full scan of 987654 -> o_valid, 0x987654.
REQ-034 Two consecutive scans 000000 then 999999 -> two o_valid pulses, values 0x000000 then 0x999999, data held between pulses.

Source files
------------

// File: rtl/s7_pkg.sv
// Shared seven-segment definitions: active-high segment patterns (bit6=g .. bit0=a)
// and the scan-decoder FSM state encoding, used by both decoder and display driver.
package s7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Encode a BCD digit into its active-high segment pattern (blank for 10..15).
    function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] digit);
        logic [SEG_W-1:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/s7_seg_decode.sv
// Combinational seven-segment to BCD decoder. Input is an active-high pattern
// (bit6=g .. bit0=a); bcd_ok drops for any pattern that is not a digit 0..9.
module s7_seg_decode
    import s7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       bcd_ok
);

    // Exact-match lookup; anything outside the ten digit shapes is rejected.
    always_comb begin
        bcd    = 4'd0;
        bcd_ok = 1'b1;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: bcd_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/s7_scan_decoder.sv
// Reconstructs a multiplexed seven-segment display into a BCD frame.
// Each digit dwell must be stable for SETTLE cycles before it is captured into a
// shadow register; once every digit has been captured the frame is published on
// o_bcd_data with a one-cycle o_valid pulse.
module s7_scan_decoder
    import s7_pkg::*;
#(
    parameter int DIS_NUM        = 6,
    parameter int SETTLE         = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
)
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [6:0]             i_segments,
    input  logic [DIS_NUM-1:0]     i_segments_sel,
    output logic [4*DIS_NUM-1:0]   o_bcd_data,
    output logic                   o_valid,
    output logic                   o_err
);

    localparam int IDX_W = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;

    // Idle line levels double as XOR masks that normalise inputs to active-high.
    localparam logic [6:0]         SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIS_NUM-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {DIS_NUM{1'b1}}
                                                                     : {DIS_NUM{1'b0}};

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    // With SETTLE of 1 the first stable cycle is already enough to capture.
    localparam logic       CAP_ON_ENTRY = (SETTLE <= 1);
    localparam state_t     DWELL_STATE  = (SETTLE <= 1) ? ST_HOLD : ST_SETTLE;

    // Position of the single set bit of a one-hot select.
    function automatic logic [IDX_W-1:0] onehot_index(input logic [DIS_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIS_NUM; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [6:0]           seg_p0;
    logic [DIS_NUM-1:0]   sel_p0;
    logic [6:0]           seg_n;
    logic [DIS_NUM-1:0]   sel_n;
    logic                 sel_ok;
    logic [IDX_W-1:0]     sel_idx;
    logic [3:0]           dig_bcd;
    logic                 dig_ok;

    state_t               state;
    logic [3:0]           cnt;
    logic [DIS_NUM-1:0]   ref_sel;
    logic [6:0]           ref_seg;
    logic                 changed;
    logic                 settled;
    logic                 capture;
    logic                 cap_ok;

    logic [DIS_NUM-1:0]   mask;
    logic [4*DIS_NUM-1:0] shadow;
    logic                 frame_done;

    // Input stage: register the raw display lines once; reset to the dark/idle levels.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seg_p0 <= SEG_IDLE;
            sel_p0 <= SEL_IDLE;
        end else begin
            seg_p0 <= i_segments;
            sel_p0 <= i_segments_sel;
        end
    end

    assign seg_n   = seg_p0 ^ SEG_IDLE;
    assign sel_n   = sel_p0 ^ SEL_IDLE;
    assign sel_ok  = (sel_n != '0) && ((sel_n & (sel_n - 1'b1)) == '0);
    assign sel_idx = onehot_index(sel_n);

    s7_seg_decode u_seg_decode (
        .seg    (seg_n),
        .bcd    (dig_bcd),
        .bcd_ok (dig_ok)
    );

    assign changed = (sel_n != ref_sel) || (seg_n != ref_seg);
    assign settled = ((cnt + 4'd1) == SETTLE_CNT);

    // Capture decision: the cycle on which the current dwell reaches its settle count.
    always_comb begin
        capture = 1'b0;
        case (state)
            ST_IDLE:   capture = sel_ok && CAP_ON_ENTRY;
            ST_SETTLE: capture = sel_ok && (changed ? CAP_ON_ENTRY : settled);
            ST_HOLD:   capture = sel_ok && changed && CAP_ON_ENTRY;
            default:   capture = 1'b0;
        endcase
    end

    assign cap_ok = capture && dig_ok;

    // Dwell tracker: restart on any change of select/segments, hold after capture
    // so a digit is taken at most once per dwell, drop to IDLE on a bad select.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ref_sel <= '0;
            ref_seg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_ok) begin
                        state   <= DWELL_STATE;
                        cnt     <= 4'd1;
                        ref_sel <= sel_n;
                        ref_seg <= seg_n;
                    end
                end
                ST_SETTLE: begin
                    if (!sel_ok) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        state   <= DWELL_STATE;
                        cnt     <= 4'd1;
                        ref_sel <= sel_n;
                        ref_seg <= seg_n;
                    end else if (settled) begin
                        state <= ST_HOLD;
                        cnt   <= cnt + 4'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!sel_ok) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        state   <= DWELL_STATE;
                        cnt     <= 4'd1;
                        ref_sel <= sel_n;
                        ref_seg <= seg_n;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign frame_done = (mask == {DIS_NUM{1'b1}});

    // Frame assembly: write captured digits into the shadow, publish when every
    // digit is present; a capture on the publishing cycle starts the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mask       <= '0;
            shadow     <= '0;
            o_bcd_data <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_valid <= frame_done;
            o_err   <= capture && !dig_ok;
            if (frame_done) begin
                o_bcd_data <= shadow;
            end
            mask <= (frame_done ? {DIS_NUM{1'b0}} : mask) | (cap_ok ? sel_n : {DIS_NUM{1'b0}});
            if (cap_ok) begin
                shadow[4*sel_idx +: 4] <= dig_bcd;
            end
        end
    end

endmodule

// File: tb/tb_s7_scan_decoder.sv
// Scoreboard bench for s7_scan_decoder: stimulus pushes expected o_valid / o_err
// events, a negedge monitor pops and compares them and checks data hold.
module tb_s7_scan_decoder;
    import s7_pkg::*;

    localparam int DIS_NUM = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  segs = 7'h7F;
    logic [5:0]  sel  = 6'h3F;
    logic [23:0] bcd;
    logic        vld;
    logic        err;

    typedef struct packed {
        logic        is_err;
        logic [23:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] model_held = '0;

    always #5 clk = ~clk;

    s7_scan_decoder #(
        .DIS_NUM(DIS_NUM), .SETTLE(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_segments     (segs),
        .i_segments_sel (sel),
        .o_bcd_data     (bcd),
        .o_valid        (vld),
        .o_err          (err)
    );

    // Active-high g..a shapes, written out independently of the design package.
    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic take(input logic is_err, input logic [23:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event is_err=%0b data=%h required=none", is_err, d);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err !== is_err || (!is_err && e.data !== d)) begin
                errors++;
                $display("FAIL event got is_err=%0b data=%h required is_err=%0b data=%h",
                         is_err, d, e.is_err, e.data);
            end
            if (!e.is_err) model_held = e.data;
        end
    endtask

    // Monitor: compare every presented event and check the frame holds otherwise.
    always @(negedge clk) begin
        if (rst) begin
            model_held = '0;
        end else begin
            if (err) take(1'b1, 24'h0);
            if (vld) take(1'b0, bcd);
            if (!vld) begin
                checks++;
                if (bcd !== model_held) begin
                    errors++;
                    $display("FAIL hold got=%h required=%h", bcd, model_held);
                end
            end
        end
    end

    task automatic drive_raw(input int k, input logic [6:0] p, input int cyc);
        sel  = ~6'(1 << k);
        segs = ~p;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int d, input int cyc);
        drive_raw(k, pat(d), cyc);
    endtask

    task automatic idle_bus(input int cyc);
        sel  = 6'h3F;
        segs = 7'h7F;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [23:0] val, input int cyc);
        for (int k = 0; k < DIS_NUM; k++) drive(k, int'(val[4*k +: 4]), cyc);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_data", 32'(bcd), 32'h0);
        check_val("rst_valid", 32'(vld), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        idle_bus(3);

        // Full scan of 123456, 4 cycles per digit
        exp_q.push_back('{1'b0, 24'h123456});
        scan(24'h123456, 4);
        idle_bus(4);
        drain("scan_123456");

        // One-cycle dwells never settle
        for (int k = 0; k < DIS_NUM; k++) drive(k, k + 1, 1);
        idle_bus(6);
        check_val("short_dwell_mask", 32'(dut.mask), 32'h0);
        drain("short_dwell");

        // Invalid pattern on digit 3: one error pulse, frame stays incomplete
        exp_q.push_back('{1'b1, 24'h0});
        drive(0, 1, 4);
        drive(1, 2, 4);
        drive(2, 3, 4);
        drive_raw(3, 7'h49, 4);
        drive(4, 5, 4);
        drive(5, 6, 4);
        idle_bus(8);
        drain("bad_digit_err");
        check_val("bad_digit_mask", 32'(dut.mask), 32'h37);
        exp_q.push_back('{1'b0, 24'h657321});
        drive(3, 7, 4);
        idle_bus(4);
        drain("bad_digit_fixed");

        // Multi-hot select forces IDLE with no capture
        sel  = ~6'b000011;
        segs = ~pat(8);
        repeat (10) @(posedge clk);
        #1;
        check_val("multihot_state", 32'(dut.state), 32'(ST_IDLE));
        check_val("multihot_mask", 32'(dut.mask), 32'h0);
        idle_bus(4);
        drain("multihot");

        // Back-to-back frames 000000 then 999999
        exp_q.push_back('{1'b0, 24'h000000});
        exp_q.push_back('{1'b0, 24'h999999});
        scan(24'h000000, 4);
        scan(24'h999999, 4);
        idle_bus(4);
        drain("two_frames");

        // Reset mid-frame discards the partial frame
        drive(0, 4, 4);
        drive(1, 3, 4);
        drive(2, 2, 4);
        drive(3, 1, 4);
        rst = 1'b1;
        #2;
        check_val("midrst_data", 32'(bcd), 32'h0);
        check_val("midrst_valid", 32'(vld), 32'h0);
        check_val("midrst_err", 32'(err), 32'h0);
        check_val("midrst_mask", 32'(dut.mask), 32'h0);
        idle_bus(2);
        rst = 1'b0;
        idle_bus(2);
        exp_q.push_back('{1'b0, 24'h987654});
        scan(24'h987654, 4);
        idle_bus(4);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
